// File: rtl/mitll_pipe_pkg.sv
// mitll_pipe_pkg: op codes and per-bit op evaluation for the clocked logic pipe.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package mitll_pipe_pkg;

  localparam logic [2:0] OP_BUF         = 3'd0;
  localparam logic [2:0] OP_NOT         = 3'd1;
  localparam logic [2:0] OP_AND         = 3'd2;
  localparam logic [2:0] OP_OR          = 3'd3;
  localparam logic [2:0] OP_XOR         = 3'd4;
  localparam logic [2:0] OP_XNOR        = 3'd5;
  localparam logic [2:0] OP_ILLEGAL_MIN = 3'd6;

  // Illegal codes fall into the default and yield 0, which is the required result.
  function automatic logic op_bit(input logic [2:0] op, input logic a, input logic b);
    case (op)
      OP_BUF:  op_bit = a;
      OP_NOT:  op_bit = ~a;
      OP_AND:  op_bit = a & b;
      OP_OR:   op_bit = a | b;
      OP_XOR:  op_bit = a ^ b;
      OP_XNOR: op_bit = ~(a ^ b);
      default: op_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mitll_pipe_stage.sv
// mitll_pipe_stage: one DFF stage holding {valid, data, err}.
// Latency: 1 cycle.
// Backpressure: none, advances every cycle.
module mitll_pipe_stage #(
  parameter int DW = 16
) (
  input  logic          C,
  input  logic          RN,
  input  logic          d_valid,
  input  logic [DW-1:0] d_data,
  input  logic          d_err,
  output logic          q_valid,
  output logic [DW-1:0] q_data,
  output logic          q_err
);

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_err   <= 1'b0;
    end else begin
      q_valid <= d_valid;
      q_data  <= d_data;
      q_err   <= d_err;
    end
  end

endmodule

// File: rtl/mitll_logic_pipe.sv
// mitll_logic_pipe: multi-channel bitwise op unit with DEPTH-stage valid-tagged pipeline.
// Latency: exactly DEPTH cycles, full throughput. Optional counters via MITLL_PIPE_STATS_EN.
// Backpressure: none; beats are never stalled.
module mitll_logic_pipe
  import mitll_pipe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 3,
  parameter int CNT_W    = 16
) (
  input  logic                      C,
  input  logic                      RN,
  input  logic                      IN_VALID,
  input  logic [2:0]                OP,
  input  logic [CHANNELS-1:0]       CH_EN,
  input  logic [CHANNELS*WIDTH-1:0] A,
  input  logic [CHANNELS*WIDTH-1:0] B,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic                      OUT_VALID,
  output logic                      OP_ERR,
`ifdef MITLL_PIPE_STATS_EN
  output logic                      BUSY,
  input  logic                      CLR_STATS,
  output logic [CNT_W-1:0]          BEAT_CNT,
  output logic [CNT_W-1:0]          ERR_CNT
`else
  output logic                      BUSY
`endif
);

  localparam int DW = CHANNELS * WIDTH;

  if (WIDTH < 1 || CHANNELS < 1 || DEPTH < 1 || CNT_W < 1) begin : g_bad_cfg
  end

  logic [DEPTH:0] vld;
  logic [DEPTH:0] err;
  logic [DW-1:0]  dat [DEPTH+1];

  logic [DW-1:0] op_dat;
  logic          op_err;

  // Bubbles and disabled channels carry zero so Q is 0 whenever OUT_VALID is 0.
  always_comb begin
    op_dat = '0;
    op_err = 1'b0;
    if (IN_VALID) begin
      op_err = (OP >= OP_ILLEGAL_MIN);
      for (int k = 0; k < CHANNELS; k++) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (CH_EN[k]) op_dat[k*WIDTH+j] = op_bit(OP, A[k*WIDTH+j], B[k*WIDTH+j]);
        end
      end
    end
  end

  assign vld[0] = IN_VALID;
  assign dat[0] = op_dat;
  assign err[0] = op_err;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    mitll_pipe_stage #(.DW(DW)) u_stage (
      .C       (C),
      .RN      (RN),
      .d_valid (vld[i]),
      .d_data  (dat[i]),
      .d_err   (err[i]),
      .q_valid (vld[i+1]),
      .q_data  (dat[i+1]),
      .q_err   (err[i+1])
    );
  end

  assign Q         = dat[DEPTH];
  assign OUT_VALID = vld[DEPTH];
  assign OP_ERR    = err[DEPTH];
  assign BUSY      = |vld[DEPTH:1];

`ifdef MITLL_PIPE_STATS_EN
  // Clear wins over a coincident increment; both counters saturate.
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      BEAT_CNT <= '0;
      ERR_CNT  <= '0;
    end else if (CLR_STATS) begin
      BEAT_CNT <= '0;
      ERR_CNT  <= '0;
    end else if (IN_VALID) begin
      if (BEAT_CNT != '1) BEAT_CNT <= BEAT_CNT + CNT_W'(1);
      if (OP >= OP_ILLEGAL_MIN && ERR_CNT != '1) ERR_CNT <= ERR_CNT + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mitll_logic_pipe.sv
// Directed bench for mitll_logic_pipe: 2x8-bit DEPTH=3 unit plus a 1x4-bit DEPTH=1 unit.
// Counter checks are compiled only with MITLL_PIPE_STATS_EN.
module tb_mitll_logic_pipe;

  logic        C = 1'b0;
  logic        RN = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [2:0]  OP = 3'd0;
  logic [1:0]  CH_EN = 2'b11;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] Q;
  logic        OUT_VALID, OP_ERR, BUSY;

  logic        CH_EN1 = 1'b1;
  logic [3:0]  A1 = '0;
  logic [3:0]  B1 = '0;
  logic [3:0]  Q1;
  logic        OUT_VALID1, OP_ERR1, BUSY1;

  int n_chk = 0;
  int n_pass = 0;
  int seen;

`ifdef MITLL_PIPE_STATS_EN
  logic        CLR_STATS = 1'b0;
  logic [1:0]  BEAT_CNT, ERR_CNT;
  logic [15:0] BEAT_CNT1, ERR_CNT1;
`endif

  mitll_logic_pipe #(.WIDTH(8), .CHANNELS(2), .DEPTH(3), .CNT_W(2)) dut (
    .C(C), .RN(RN), .IN_VALID(IN_VALID), .OP(OP), .CH_EN(CH_EN), .A(A), .B(B),
    .Q(Q), .OUT_VALID(OUT_VALID), .OP_ERR(OP_ERR),
`ifdef MITLL_PIPE_STATS_EN
    .BUSY(BUSY), .CLR_STATS(CLR_STATS), .BEAT_CNT(BEAT_CNT), .ERR_CNT(ERR_CNT)
`else
    .BUSY(BUSY)
`endif
  );

  mitll_logic_pipe #(.WIDTH(4), .CHANNELS(1), .DEPTH(1), .CNT_W(16)) dut1 (
    .C(C), .RN(RN), .IN_VALID(IN_VALID), .OP(OP), .CH_EN(CH_EN1), .A(A1), .B(B1),
    .Q(Q1), .OUT_VALID(OUT_VALID1), .OP_ERR(OP_ERR1),
`ifdef MITLL_PIPE_STATS_EN
    .BUSY(BUSY1), .CLR_STATS(CLR_STATS), .BEAT_CNT(BEAT_CNT1), .ERR_CNT(ERR_CNT1)
`else
    .BUSY(BUSY1)
`endif
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  initial begin
    #1 RN = 1'b0;
    #1;
    chk("rst_q", Q, 0);
    chk("rst_vld", OUT_VALID, 0);
    chk("rst_err", OP_ERR, 0);
    chk("rst_busy", BUSY, 0);
    step();
    step();
    RN = 1'b1;

    // AND beat, latency 3, BUSY window
    A = 16'hF00F; B = 16'hFF00; OP = 3'd2; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    chk("and_busy1", BUSY, 1);
    chk("and_vld1", OUT_VALID, 0);
    step();
    chk("and_busy2", BUSY, 1);
    chk("and_vld2", OUT_VALID, 0);
    step();
    chk("and_vld3", OUT_VALID, 1);
    chk("and_q", Q, 16'hF000);
    chk("and_err", OP_ERR, 0);
    chk("and_busy3", BUSY, 1);
    step();
    chk("and_busy4", BUSY, 0);
    chk("and_vld4", OUT_VALID, 0);
    chk("and_q4", Q, 0);

    // back-to-back XOR, XNOR, NOT
    A = 16'hAA55; B = 16'h0F0F; OP = 3'd4; IN_VALID = 1'b1;
    step();
    OP = 3'd5;
    step();
    OP = 3'd1;
    step();
    IN_VALID = 1'b0;
    chk("b2b_q0", Q, 16'hA55A);
    chk("b2b_v0", OUT_VALID, 1);
    step();
    chk("b2b_q1", Q, 16'h5AA5);
    chk("b2b_v1", OUT_VALID, 1);
    step();
    chk("b2b_q2", Q, 16'h55AA);
    chk("b2b_v2", OUT_VALID, 1);
    step();
    chk("b2b_vend", OUT_VALID, 0);

    // inputs ignored while IN_VALID=0
    A = 16'hFFFF; B = 16'hFFFF; OP = 3'd3;
    step();
    step();
    step();
    chk("idle_v", OUT_VALID, 0);
    chk("idle_q", Q, 0);
    chk("idle_busy", BUSY, 0);

    // channel mask
    CH_EN = 2'b01; OP = 3'd3; A = 16'h1234; B = 16'h0000; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0; CH_EN = 2'b11;
    step();
    step();
    chk("mask_q", Q, 16'h0034);
    chk("mask_v", OUT_VALID, 1);

    // illegal op
    OP = 3'd7; A = 16'hFFFF; B = 16'hFFFF; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    step();
    chk("ill_q", Q, 0);
    chk("ill_v", OUT_VALID, 1);
    chk("ill_err", OP_ERR, 1);
    step();
    chk("ill_err_after", OP_ERR, 0);

    // DEPTH=1 instance: one-cycle latency
    OP = 3'd4; A1 = 4'hC; B1 = 4'hA; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    chk("d1_q", Q1, 4'h6);
    chk("d1_v", OUT_VALID1, 1);
    step();
    chk("d1_v_end", OUT_VALID1, 0);
    chk("d1_q_end", Q1, 0);
    step();
    step();

    // async reset mid-flight
    OP = 3'd0; A = 16'h1357; IN_VALID = 1'b1;
    step();
    A = 16'h2468;
    step();
    IN_VALID = 1'b0;
    step();
    chk("rf_q_pre", Q, 16'h1357);
    chk("rf_v_pre", OUT_VALID, 1);
    #3 RN = 1'b0;
    #1;
    chk("rf_q", Q, 0);
    chk("rf_v", OUT_VALID, 0);
    chk("rf_busy", BUSY, 0);
`ifdef MITLL_PIPE_STATS_EN
    chk("rf_beat", BEAT_CNT, 0);
    chk("rf_errc", ERR_CNT, 0);
`endif
    #2 RN = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (OUT_VALID) seen++;
    end
    chk("rf_no_vld", seen, 0);

`ifdef MITLL_PIPE_STATS_EN
    // counters: illegal beat, saturation at 3, clear priority
    OP = 3'd7; IN_VALID = 1'b1;
    step();
    chk("st_beat1", BEAT_CNT, 1);
    chk("st_err1", ERR_CNT, 1);
    OP = 3'd2;
    for (int i = 0; i < 4; i++) step();
    chk("st_beat_sat", BEAT_CNT, 3);
    chk("st_err_hold", ERR_CNT, 1);
    CLR_STATS = 1'b1;
    step();
    CLR_STATS = 1'b0; IN_VALID = 1'b0;
    chk("st_clr_beat", BEAT_CNT, 0);
    chk("st_clr_err", ERR_CNT, 0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
